// File: rtl/ccip_rd_arbiter.sv
// rtl/ccip_rd_arbiter.sv - round-robin arbiter for the CCI-P c0 read-request channel
//
// Shares the c0 read-request channel between NUM_REQS requesters. Requesters
// are granted round-robin. The requester index is stamped into mdata above
// the requester tag. Read responses are routed back by decoding that index.
// Each requester has its own outstanding-read count. Once a requester reaches
// MAX_OUTSTANDING it is not granted, so it cannot starve the others.
//
// Optional feature: define CCIP_RD_ARB_PERF_EN to build the almost-full
// stall counter. Without it, stall_cycles is tied to zero.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/addr/tag  per-requester read requests (flattened vectors)
//   req_ready           combinational grant, one bit per requester
//   c0_almfull          channel almost-full; blocks new grants
//   c0_tx_valid/addr/mdata   registered c0 read request to the channel
//   c0_rx_rspvalid/mdata/data  c0 read response from the channel
//   rsp_valid/tag/data  registered, routed response (one-hot strobe)
//   outstanding         per-requester in-flight count, 5 bits each
//   err                 sticky: a response with a bad index or zero count
//   stall_cycles        cycles spent with almfull and a pending request

module ccip_rd_arbiter #(
    parameter int NUM_REQS        = 2,
    parameter int ADDR_WIDTH      = 42,
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
    output logic [NUM_REQS-1:0]              req_ready,
    input  logic                             c0_almfull,
    output logic                             c0_tx_valid,
    output logic [ADDR_WIDTH-1:0]            c0_tx_addr,
    output logic [15:0]                      c0_tx_mdata,
    input  logic                             c0_rx_rspvalid,
    input  logic [15:0]                      c0_rx_mdata,
    input  logic [511:0]                     c0_rx_data,
    output logic [NUM_REQS-1:0]              rsp_valid,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    output logic [511:0]                     rsp_data,
    output logic [NUM_REQS*5-1:0]            outstanding,
    output logic                             err,
    output logic [31:0]                      stall_cycles
);

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [IDX_W-1:0]       rr;
    logic [4:0]             cnt [NUM_REQS];

    logic [NUM_REQS-1:0]    eligible;
    logic [NUM_REQS-1:0]    grant;
    logic                   grant_any;
    logic [IDX_W-1:0]       grant_idx;
    // One bit wider than the index so rr + offset cannot wrap before the
    // explicit modulo subtraction.
    logic [IDX_W:0]         cand;

    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [TAG_WIDTH-1:0]   sel_tag;
    logic [15:0]            sel_mdata;

    logic [IDX_W-1:0]       rx_idx;
    logic [NUM_REQS-1:0]    idx_hit;
    logic [NUM_REQS-1:0]    cnt_nonzero;
    logic                   rsp_ok;
    logic                   rsp_bad;

    // The upper mdata bits are not part of the routing decode.
    logic [15:0]            unused_mdata;
    assign unused_mdata = c0_rx_mdata;

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    always_comb begin
        eligible  = '0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid[i] && (cnt[i] < 5'(MAX_OUTSTANDING));
        end
        if (!c0_almfull) begin
            // Walk the requesters starting at the pointer. The inner loop
            // keeps every bit select constant.
            for (int k = 0; k < NUM_REQS; k++) begin
                cand = {1'b0, rr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQS)) begin
                    cand = cand - (IDX_W+1)'(NUM_REQS);
                end
                for (int i = 0; i < NUM_REQS; i++) begin
                    if (!grant_any && cand == (IDX_W+1)'(i) && eligible[i]) begin
                        grant_any = 1'b1;
                        grant_idx = IDX_W'(i);
                        grant[i]  = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = grant;

    // Select the granted requester's address and tag, then build the header.
    always_comb begin
        sel_addr  = '0;
        sel_tag   = '0;
        sel_mdata = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
        sel_mdata[TAG_WIDTH-1:0]       = sel_tag;
        sel_mdata[TAG_WIDTH +: IDX_W]  = grant_idx;
    end

    // ------------------------------------------------------------------
    // Response decode
    // ------------------------------------------------------------------
    assign rx_idx = c0_rx_mdata[TAG_WIDTH +: IDX_W];

    // An index at or above NUM_REQS matches no requester. It is therefore
    // rejected by the same path as a response to an idle requester.
    always_comb begin
        idx_hit     = '0;
        cnt_nonzero = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            idx_hit[i]     = (rx_idx == IDX_W'(i));
            cnt_nonzero[i] = (cnt[i] != 5'd0);
        end
    end

    assign rsp_ok  = c0_rx_rspvalid &&  (|(idx_hit & cnt_nonzero));
    assign rsp_bad = c0_rx_rspvalid && !(|(idx_hit & cnt_nonzero));

    // ------------------------------------------------------------------
    // Tx request register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0_tx_valid <= 1'b0;
            c0_tx_addr  <= '0;
            c0_tx_mdata <= '0;
            rr          <= '0;
        end else begin
            c0_tx_valid <= grant_any;
            if (grant_any) begin
                c0_tx_addr  <= sel_addr;
                c0_tx_mdata <= sel_mdata;
                rr          <= (grant_idx == IDX_W'(NUM_REQS-1)) ? '0
                                                                 : grant_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                // A grant and a response in the same cycle cancel out.
                if (grant[i] && !(rsp_ok && idx_hit[i])) begin
                    cnt[i] <= cnt[i] + 5'd1;
                end else if (!grant[i] && rsp_ok && idx_hit[i]) begin
                    cnt[i] <= cnt[i] - 5'd1;
                end
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            outstanding[i*5 +: 5] = cnt[i];
        end
    end

    // ------------------------------------------------------------------
    // Response register and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= rsp_ok ? idx_hit : '0;
            if (rsp_ok) begin
                rsp_tag  <= c0_rx_mdata[TAG_WIDTH-1:0];
                rsp_data <= c0_rx_data;
            end
            if (rsp_bad) begin
                err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Almost-full stall counter
    // ------------------------------------------------------------------
`ifdef CCIP_RD_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (c0_almfull && (|req_valid) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/ccip_rd_arbiter.md
Name: ccip_rd_arbiter

Overview:
- Shares the CCI-P c0 read-request channel between NUM_REQS internal requesters, such as the command reader and the memory-copy engine inside the AFU.
- Arbitrates round-robin and honours c0TxAlmFull.
- Stamps the requester index into mdata, and routes c0 read responses back to the owning requester.
- Tracks outstanding reads per requester, so no single requester can starve the others.

Parameters:
- NUM_REQS, 2, number of requesters (2..4); IDX_W = clog2(NUM_REQS), minimum 1.
- ADDR_WIDTH, 42, cache-line address width (t_ccip_clAddr).
- TAG_WIDTH, 8, per-requester tag width. Constraint: TAG_WIDTH + IDX_W <= 16.
- MAX_OUTSTANDING, 16, per-requester in-flight read limit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQS  read request valid, one bit per requester
- req_addr  in  NUM_REQS*ADDR_WIDTH  cache-line address per requester
- req_tag  in  NUM_REQS*TAG_WIDTH  requester tag
- req_ready  out  NUM_REQS  request accepted this cycle
- c0_almfull  in  1  cp2af c0TxAlmFull
- c0_tx_valid  out  1  af2cp c0 valid (registered)
- c0_tx_addr  out  ADDR_WIDTH  af2cp c0 hdr address
- c0_tx_mdata  out  16  af2cp c0 hdr mdata
- c0_rx_rspvalid  in  1  cp2af c0 rspValid
- c0_rx_mdata  in  16  cp2af c0 rspMemHdr mdata
- c0_rx_data  in  512  cp2af c0 data
- rsp_valid  out  NUM_REQS  one-hot response strobe
- rsp_tag  out  TAG_WIDTH  returned tag
- rsp_data  out  512  returned cache line
- outstanding  out  NUM_REQS*5  per-requester in-flight count
- err  out  1  sticky protocol error
- stall_cycles  out  32  almost-full stall counter (see Optional Feature)

Behaviour:
- Reset values: all outputs are 0. Round-robin pointer = 0. Counters = 0. err = 0.
- Eligibility: requester i is eligible when req_valid[i] && outstanding[i] < MAX_OUTSTANDING.
- Grant: when !c0_almfull, grant the first eligible requester at or after the RR pointer. At most one grant per cycle.
- req_ready[i] = grant[i], combinational in the same cycle. The request is accepted when valid && ready.
- No grants are issued while c0_almfull = 1. req_ready is then all zeros, and any in-flight registered valid still completes. CCI-P allows 8 further requests after almfull asserts, so this is safe.
- Tx register: on a grant, the next cycle drives c0_tx_valid = 1, c0_tx_addr = req_addr[i], and c0_tx_mdata = {zeros, i[IDX_W-1:0], req_tag[i]}. With no grant, c0_tx_valid = 0; addr/mdata hold their last values. Request-to-channel latency is exactly 1 cycle.
- RR pointer: after a grant to i, the pointer becomes (i+1) mod NUM_REQS. With no grant, it is unchanged.
- Outstanding counters:
  - +1 on a grant to i.
  - -1 on an accepted response for i.
  - A grant and a response for the same i in the same cycle leave the count unchanged.
- Response decode: idx = c0_rx_mdata[TAG_WIDTH +: IDX_W]. On c0_rx_rspvalid, the next cycle drives:
  - rsp_valid = onehot(idx)
  - rsp_tag = c0_rx_mdata[TAG_WIDTH-1:0]
  - rsp_data = c0_rx_data
  Response latency is exactly 1 cycle. There is no backpressure, so requesters must sink every response.
- Bad response: if idx >= NUM_REQS, or outstanding[idx] == 0, the response is dropped (no rsp_valid), the counter is not decremented (no underflow), and err is set.
- err is cleared only by reset.
- Reset mid-operation: all counters clear and err clears. Responses that arrive after reset for pre-reset reads hit outstanding == 0, so they are dropped and set err. Software drains the channel before reset.
- The block never inspects MMIO; MMIO frames must not assert c0_rx_rspvalid.

Optional Feature:
- Macro: CCIP_RD_ARB_PERF_EN.
- Defined: stall_cycles increments every cycle where c0_almfull && |req_valid. It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Single request: req_valid[0] = 1, addr 0x123, tag 0x5A. Required: req_ready[0] in the same cycle; the next cycle c0_tx_valid = 1, addr 0x123, mdata 0x005A; outstanding[0] = 1.
- Fairness: both requesters continuously valid for 6 cycles, almfull = 0. Required: grants alternate 0,1,0,1,0,1; outstanding = 3/3.
- Almost-full: hold c0_almfull = 1 for 4 cycles with requests pending. Required: req_ready = 0 for those cycles; with PERF_EN, stall_cycles = 4; grants resume the cycle almfull drops.
- Credit limit: issue 16 reads on requester 1 with no responses. Required: the 17th is held off (req_ready[1] = 0) while requester 0 is still granted. Then a response with mdata 0x01AB gives, the next cycle, rsp_valid = 2'b10, rsp_tag = 0xAB, and outstanding[1] = 15.
- Simultaneous: a grant to 0 and a response for 0 in the same cycle leave outstanding[0] unchanged.
- Errors:
  - A response with mdata idx = 1 while outstanding[1] = 0 → no rsp_valid, err = 1, counter stays 0.
  - Assert reset → err = 0.
